piso_shift_tx: RTL
==================

Name: piso_shift_tx

Overview:
Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out LSB first on a single-bit serial line. Each bit is held for BIT_CYCLES clocks. It is the send-side counterpart to the processor's flip-flop-based serial capture/storage path, and it feeds inter-block serial links and debug taps.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
BIT_CYCLES, 1, clocks each bit is held on sout; legal range 1..256.

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
load_valid  input  1  producer has a word on load_data.
load_data  input  WIDTH  word to transmit; sampled only on a handshake.
load_ready  output  1  block can accept a word this cycle.
sout  output  1  serial data, LSB first.
sout_valid  output  1  sout carries a frame bit.
sout_last  output  1  the bit on sout is bit WIDTH-1 of the current word.
busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, shift register=0, bit counter=0, cycle counter=0.
  - sout=0, sout_valid=0, sout_last=0, busy=0.
  - load_ready forced to 0 while reset is high.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1; sout=0, sout_valid=0, sout_last=0.
  - On load_valid && load_ready at a clock edge: shreg<=load_data, bitcnt<=0, cyccnt<=0, state<=SHIFT.
- SHIFT:
  - Outputs: sout=shreg[0], sout_valid=1, busy=1, sout_last=(bitcnt==WIDTH-1).
  - Each clock: cyccnt increments. When cyccnt==BIT_CYCLES-1, the bit period ends: cyccnt<=0, shreg shifts right with zero fill, bitcnt increments.
- End of word (final cycle of the last bit, i.e. bitcnt==WIDTH-1 && cyccnt==BIT_CYCLES-1):
  - load_ready=1 in this cycle.
  - If load_valid is high: the new word loads exactly as from IDLE, and its bit0 appears the next cycle. Back-to-back words have no gap.
  - Otherwise: state<=IDLE.
- load_ready=0 in every other SHIFT cycle. load_valid asserted there is ignored and load_data is not sampled.
- Latency: a handshake at edge N puts bit0 on sout during cycles N+1 .. N+BIT_CYCLES. A word occupies exactly WIDTH*BIT_CYCLES cycles.
- Outputs are registered or decoded from registered state only; there is no combinational path from load_* to sout.
- Counter widths: bitcnt is clog2(WIDTH) bits, cyccnt is clog2(BIT_CYCLES) bits (minimum 1). Neither may wrap before its terminal compare.
- BIT_CYCLES=1: the bit period ends every cycle, so cyccnt is constant 0.
- Reset asserted mid-word aborts the frame immediately: sout_valid drops asynchronously and the partial word is discarded. After reset deasserts, the block is in IDLE with load_ready=1 on the first clock.
- load_data X/unknown outside a handshake has no effect.

Decomposition:
- Shared package piso_pkg holds:
  - the state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - a clog2 helper function used for counter widths.
- One sub-module is natural: bit_timer (parameter BIT_CYCLES; ports clk, reset, run, tick). It owns cyccnt and pulses tick in the final cycle of each bit period. piso_shift_tx owns the state machine, shreg and bitcnt.

Test Plan:
- Reset then idle, WIDTH=8, BIT_CYCLES=1 -> load_ready=1 on the first clock after reset; sout=0, sout_valid=0, busy=0.
- Load 8'hA5 with BIT_CYCLES=1 -> over 8 cycles sout = 1,0,1,0,0,1,0,1; sout_last high only on the 8th; IDLE on the 9th.
- Load 8'h81 with BIT_CYCLES=4 -> each bit held 4 cycles (32 cycles total); load_valid pulsed mid-word is ignored and load_ready stays 0 until cycle 32.
- Back-to-back: load 8'hFF, keep load_valid high with 8'h00 queued -> second handshake in cycle 8; sout = 8 ones then 8 zeros with no gap; sout_valid stays 1 for 16 cycles.
- Reset pulsed during bit 3 of 8'h3C -> sout_valid=0 and busy=0 asynchronously; after release, 8'h01 loads and transmits correctly from bit0.
- WIDTH=2, BIT_CYCLES=3, load 2'b10 -> sout = 0,0,0,1,1,1; sout_last high for the last 3 cycles only.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the parallel-in, serial-out transmitter.
//   ST_IDLE / ST_SHIFT : state encoding for piso_shift_tx
//   clog2()            : ceil(log2(value)), never less than 1, used to size counters
package piso_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Minimum of 1 so a counter for a single-valued range still has a legal width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = unsigned'(i + 1);
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_shift_tx_bit_timer.sv
// bit_timer: counts clocks within one serial bit period.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears the cycle counter
//   run   : count while high; counter is held at 0 while low
//   tick  : high in the final cycle of each bit period (only while run)
module bit_timer
    import piso_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned TW = clog2(BIT_CYCLES);
    localparam logic [TW-1:0] LAST_CYC = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] cyccnt_q, cyccnt_d;

    always_comb begin
        tick     = run && (cyccnt_q == LAST_CYC);
        cyccnt_d = cyccnt_q;
        // Idle or end of a bit period both restart the count, so a newly
        // loaded word always starts its first bit with a fresh period.
        if (!run || tick) begin
            cyccnt_d = '0;
        end else begin
            cyccnt_d = cyccnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyccnt_q <= '0;
        end else begin
            cyccnt_q <= cyccnt_d;
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in, serial-out transmitter, LSB first.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high; aborts any frame in flight
//   load_valid : producer offers load_data
//   load_data  : WIDTH-bit word, sampled only on load_valid && load_ready
//   load_ready : a word can be accepted this cycle (idle, or last cycle of a word)
//   sout       : serial data, each bit held BIT_CYCLES clocks
//   sout_valid : sout carries a frame bit
//   sout_last  : sout carries bit WIDTH-1 of the current word
//   busy       : a word is in flight
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int unsigned CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;

    logic shifting;
    logic tick;
    logic last_bit;
    logic load_fire;

    assign shifting = (state_q == ST_SHIFT);
    assign last_bit = (bitcnt_q == LAST_BIT);

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .run   (shifting),
        .tick  (tick)
    );

    // Outputs depend on registered state only (plus reset gating on ready).
    always_comb begin
        load_ready = !reset && (!shifting || (last_bit && tick));
        sout       = shifting && shreg_q[0];
        sout_valid = shifting;
        sout_last  = shifting && last_bit;
        busy       = shifting;
    end

    always_comb begin
        load_fire = load_valid && load_ready;
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;

        if (shifting && tick) begin
            shreg_d = shreg_q >> 1;
            if (last_bit) begin
                bitcnt_d = '0;
                state_d  = ST_IDLE;
            end else begin
                bitcnt_d = bitcnt_q + CW'(1);
            end
        end

        // A load at the end of a word overrides the return to idle: no gap.
        if (load_fire) begin
            shreg_d  = load_data;
            bitcnt_d = '0;
            state_d  = ST_SHIFT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

endmodule
